keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_scanner_debounce_counter.sv | 29 ++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 tb/tb_keypad_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, the
// (row,col) to hex key map and the idle row pattern.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DB,
      HOLD,
      RELEASE_DB
   } scan_state_t;

   localparam logic [3:0] IDLE_ROWS = 4'hF;

   // Indexed as KEY_MAP[row][col]; the rightmost nibble of each row is column 0.
   localparam logic [3:0][3:0][3:0] KEY_MAP = {
      {4'hD, 4'hF, 4'h0, 4'hE},
      {4'hC, 4'h9, 4'h8, 4'h7},
      {4'hB, 4'h6, 4'h5, 4'h4},
      {4'hA, 4'h3, 4'h2, 4'h1}
   };

   function automatic logic [1:0] low_row(input logic [3:0] rows);
      logic [1:0] idx;
      casez (rows)
         4'b???0: idx = 2'd0;
         4'b??01: idx = 2'd1;
         4'b?011: idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_debounce_counter.sv
// Saturating up-counter with synchronous clear, shared by the press and
// release debounce phases of the keypad scanner.
module debounce_counter #(
   parameter int               WIDTH    = 3,
   parameter logic [WIDTH-1:0] TERMINAL = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [WIDTH-1:0] count;

   assign done = (count == TERMINAL);

   // Holds at the terminal count instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !done) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold column drive, debounces the
// first key found and emits a single key_valid pulse with its hex code.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS      = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int SCAN_W = $clog2(SCAN_TICKS);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

   scan_state_t       state, state_next;
   logic [3:0]        sync_a, sync_b;
   logic [SCAN_W-1:0] scan_cnt, scan_cnt_next;
   logic [1:0]        col_idx, col_idx_next;
   logic [3:0]        lat_rows, lat_rows_next;
   logic              key_valid_next;
   logic [3:0]        key_code_next;
   logic              db_clear, db_enable, db_done;
   logic              scan_last;

   assign col       = ~(4'b0001 << col_idx);
   assign scan_last = (scan_cnt == SCAN_W'(SCAN_TICKS - 1));

   debounce_counter #(
      .WIDTH    (DB_W),
      .TERMINAL (DB_W'(DEBOUNCE_CYCLES - 1))
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .clear  (db_clear),
      .enable (db_enable),
      .done   (db_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a    <= IDLE_ROWS;
         sync_b    <= IDLE_ROWS;
         state     <= SCAN;
         scan_cnt  <= '0;
         col_idx   <= '0;
         lat_rows  <= IDLE_ROWS;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         sync_a    <= fil;
         sync_b    <= sync_a;
         state     <= state_next;
         scan_cnt  <= scan_cnt_next;
         col_idx   <= col_idx_next;
         lat_rows  <= lat_rows_next;
         key_valid <= key_valid_next;
         key_code  <= key_code_next;
      end
   end

   // The column stays frozen from the moment a key is seen until its release
   // has been debounced, so the row pattern keeps referring to that column.
   always_comb begin
      state_next     = state;
      scan_cnt_next  = scan_cnt;
      col_idx_next   = col_idx;
      lat_rows_next  = lat_rows;
      key_valid_next = 1'b0;
      key_code_next  = key_code;
      db_clear       = 1'b0;
      db_enable      = 1'b0;

      case (state)
         SCAN: begin
            if (scan_last) begin
               scan_cnt_next = '0;
               if (sync_b != IDLE_ROWS) begin
                  lat_rows_next = sync_b;
                  db_clear      = 1'b1;
                  state_next    = PRESS_DB;
               end else begin
                  col_idx_next = col_idx + 2'd1;
               end
            end else begin
               scan_cnt_next = scan_cnt + SCAN_W'(1);
            end
         end
         PRESS_DB: begin
            if (sync_b != lat_rows) begin
               state_next = SCAN;
            end else if (db_done) begin
               key_valid_next = 1'b1;
               key_code_next  = KEY_MAP[low_row(lat_rows)][col_idx];
               state_next     = HOLD;
            end else begin
               db_enable = 1'b1;
            end
         end
         HOLD: begin
            if (sync_b == IDLE_ROWS) begin
               db_clear   = 1'b1;
               state_next = RELEASE_DB;
            end
         end
         RELEASE_DB: begin
            if (sync_b != IDLE_ROWS) begin
               state_next = HOLD;
            end else if (db_done) begin
               col_idx_next  = col_idx + 2'd1;
               scan_cnt_next = '0;
               state_next    = SCAN;
            end else begin
               db_enable = 1'b1;
            end
         end
         default: state_next = SCAN;
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a reactive keypad model drives the
// rows from the column drive, with a vector table plus hand-written sequences.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] fil = 4'hF;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;

   logic [15:0] keys_down = '0;
   int          pulse_count = 0;
   logic [3:0]  last_code = 4'h0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      string       name;
      logic [15:0] keys;
      int          press_cycles;
      int          release_cycles;
      int          exp_pulses;
      logic [3:0]  exp_code;
   } vec_t;

   vec_t vecs[10];

   keypad_scanner #(
      .SCAN_TICKS      (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fil       (fil),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] key_mask(input int row, input int c);
      return 16'(1) << (row * 4 + c);
   endfunction

   // A pressed key at (row,c) pulls row low only while column c is driven low.
   function automatic logic [3:0] model_rows(input logic [3:0] c, input logic [15:0] k);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ~|(k[i*4 +: 4] & ~c);
      return r;
   endfunction

   always @(negedge clk) begin
      #1;
      fil = model_rows(col, keys_down);
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         pulse_count++;
         last_code = key_code;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_col(input logic [3:0] want, input logic equal, input string name);
      int n = 0;
      while (((col == want) != equal) && n < 60) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 60) begin
         bad++;
         $display("[TB] FAIL %s: timeout waiting for col %s %b (col=%b)", name,
                  equal ? "==" : "!=", want, col);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      int base;
      base = pulse_count;
      keys_down = v.keys;
      wait_cycles(v.press_cycles);
      keys_down = '0;
      wait_cycles(v.release_cycles);
      check_output({v.name, "_pulses"}, 32'(pulse_count - base), 32'(v.exp_pulses));
      check_output({v.name, "_code"}, 32'(key_code), 32'(v.exp_code));
   endtask

   initial begin
      int base;
      logic [3:0] exp_col;

      vecs[0] = '{"key4",  key_mask(1, 0), 40, 40, 1, 4'h4};
      vecs[1] = '{"key5",  key_mask(1, 1), 40, 40, 1, 4'h5};
      vecs[2] = '{"key0",  key_mask(3, 1), 40, 40, 1, 4'h0};
      vecs[3] = '{"key7",  key_mask(2, 0), 40, 40, 1, 4'h7};
      vecs[4] = '{"short", key_mask(0, 2),  3, 40, 0, 4'h7};
      vecs[5] = '{"keyD",  key_mask(3, 3), 40, 40, 1, 4'hD};
      vecs[6] = '{"keyA",  key_mask(0, 3), 40, 40, 1, 4'hA};
      vecs[7] = '{"keyE",  key_mask(3, 0), 40, 40, 1, 4'hE};
      vecs[8] = '{"multi", key_mask(1, 2) | key_mask(3, 2), 40, 40, 1, 4'h6};
      vecs[9] = '{"key9",  key_mask(2, 2), 40, 40, 1, 4'h9};

      wait_cycles(2);
      check_output("reset_col", 32'(col), 32'(4'b1110));
      check_output("reset_valid", 32'(key_valid), 32'(1'b0));
      check_output("reset_code", 32'(key_code), 32'(4'h0));

      // Idle rotation: k clock edges after reset release the drive sits on column (k/4)%4.
      rst = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         if (k <= 16) check_output($sformatf("rotate_k%0d", k), 32'(col), 32'(exp_col));
      end
      check_output("idle_no_pulse", 32'(pulse_count), 32'(0));

      keys_down = key_mask(0, 2);
      wait_cycles(39);
      check_output("key3_col_frozen", 32'(col), 32'(4'b1011));
      wait_cycles(1);
      keys_down = '0;
      check_output("key3_pulses", 32'(pulse_count), 32'(1));
      check_output("key3_code", 32'(last_code), 32'(4'h3));
      wait_cycles(4);
      check_output("key3_col_held_release", 32'(col), 32'(4'b1011));
      wait_cycles(36);
      check_output("key3_single_pulse", 32'(pulse_count), 32'(1));

      base = pulse_count;
      wait_col(4'b1101, 1'b0, "bounce_leave");
      wait_col(4'b1101, 1'b1, "bounce_enter");
      keys_down = key_mask(3, 1);
      wait_cycles(6);
      for (int i = 0; i < 4; i++) begin
         keys_down = '0;
         wait_cycles(3);
         keys_down = key_mask(3, 1);
         wait_cycles(3);
      end
      check_output("bounce_no_pulse", 32'(pulse_count - base), 32'(0));
      wait_cycles(40);
      keys_down = '0;
      wait_cycles(40);
      check_output("bounce_pulses", 32'(pulse_count - base), 32'(1));
      check_output("bounce_code", 32'(key_code), 32'(4'h0));

      base = pulse_count;
      keys_down = key_mask(1, 1);
      wait_cycles(40);
      keys_down = key_mask(1, 1) | key_mask(2, 2);
      wait_cycles(20);
      check_output("hold_col_frozen", 32'(col), 32'(4'b1101));
      keys_down = '0;
      wait_cycles(40);
      check_output("hold_pulses", 32'(pulse_count - base), 32'(1));
      check_output("hold_code", 32'(key_code), 32'(4'h5));

      for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

      base = pulse_count;
      wait_col(4'b1011, 1'b0, "rst_leave");
      wait_col(4'b1011, 1'b1, "rst_enter");
      keys_down = key_mask(1, 2);
      wait_cycles(6);
      #2 rst = 1'b0;
      #1;
      check_output("rst_async_col", 32'(col), 32'(4'b1110));
      check_output("rst_async_code", 32'(key_code), 32'(4'h0));
      check_output("rst_async_valid", 32'(key_valid), 32'(1'b0));
      wait_cycles(10);
      keys_down = '0;
      wait_cycles(2);
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         check_output($sformatf("rst_rotate_k%0d", k), 32'(col), 32'(exp_col));
      end
      wait_cycles(40);
      check_output("rst_no_pulse", 32'(pulse_count - base), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
